// File: rtl/usb_tx_pkt_scheduler.sv
// USB TX packet scheduler: arbitrates handshake vs. hash DATA packets, feeds
// 16-bit words to the TX on read_enable and holds an idle gap between packets.
module usb_tx_pkt_scheduler #(
   parameter logic [7:0] SYNC_BYTE  = 8'h80,
   parameter logic [7:0] DATA_PID   = 8'hC3,
   parameter int         GAP_CYCLES = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         hash_req,
   input  logic [255:0] hash_in,
   input  logic         hs_req,
   input  logic [7:0]   hs_pid,
   input  logic         read_enable,
   input  logic         tx_error,
   output logic [15:0]  tx_data,
   output logic         transmit_start,
   output logic         transmit_empty,
   output logic         hash_ack,
   output logic         hs_ack,
   output logic         hash_done,
   output logic         hs_done,
   output logic         pkt_err,
   output logic         busy
);

   localparam int            GW         = $clog2(GAP_CYCLES + 1);
   localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);
   localparam logic [4:0]    HASH_WORDS = 5'd16;

   typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

   state_t        state, state_next;
   logic          is_hash;
   logic          aborted;
   logic [4:0]    word_cnt;
   logic [GW-1:0] gap_cnt;
   logic [255:0]  shreg;

   logic grant_hs, grant_hash, start_pulse, shift_word, last_word, abort, gap_tick, gap_end;

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
   always_comb begin
      state_next  = state;
      grant_hs    = 1'b0;
      grant_hash  = 1'b0;
      start_pulse = 1'b0;
      shift_word  = 1'b0;
      last_word   = 1'b0;
      abort       = 1'b0;
      gap_tick    = 1'b0;
      gap_end     = 1'b0;
      unique case (state)
         IDLE: begin
            if (hs_req) begin
               grant_hs   = 1'b1;
               state_next = START;
            end else if (hash_req) begin
               grant_hash = 1'b1;
               state_next = START;
            end
         end
         START: begin
            if (tx_error) begin
               abort      = 1'b1;
               state_next = GAP;
            end else begin
               start_pulse = 1'b1;
               state_next  = SEND;
            end
         end
         SEND: begin
            if (tx_error) begin
               abort      = 1'b1;
               state_next = GAP;
            end else if (read_enable) begin
               if (is_hash && word_cnt < HASH_WORDS) begin
                  shift_word = 1'b1;
               end else begin
                  last_word  = 1'b1;
                  state_next = GAP;
               end
            end
         end
         GAP: begin
            // An error during the gap restarts it, so the bus always sees a full idle period.
            if (tx_error) begin
               abort = 1'b1;
            end else if (gap_cnt == '0) begin
               gap_end    = 1'b1;
               state_next = IDLE;
            end else begin
               gap_tick = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: the 256-bit shift register is cleared on reset too, so no stale hash survives a reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         is_hash        <= 1'b0;
         aborted        <= 1'b0;
         word_cnt       <= '0;
         gap_cnt        <= '0;
         shreg          <= '0;
         tx_data        <= '0;
         transmit_start <= 1'b0;
         transmit_empty <= 1'b1;
         hash_ack       <= 1'b0;
         hs_ack         <= 1'b0;
         hash_done      <= 1'b0;
         hs_done        <= 1'b0;
         pkt_err        <= 1'b0;
      end else begin
         transmit_start <= start_pulse;
         hash_ack       <= grant_hash;
         hs_ack         <= grant_hs;
         hash_done      <= gap_end & is_hash & ~aborted;
         hs_done        <= gap_end & ~is_hash & ~aborted;
         pkt_err        <= abort;

         if (grant_hs || grant_hash) begin
            is_hash        <= grant_hash;
            aborted        <= 1'b0;
            word_cnt       <= '0;
            transmit_empty <= 1'b0;
            tx_data        <= {SYNC_BYTE, grant_hs ? hs_pid : DATA_PID};
            shreg          <= grant_hash ? hash_in : '0;
         end

         if (shift_word) begin
            tx_data  <= shreg[255 -: 16];
            shreg    <= {shreg[239:0], 16'h0000};
            word_cnt <= word_cnt + 5'd1;
         end

         if (last_word || abort) begin
            transmit_empty <= 1'b1;
            gap_cnt        <= GAP_LOAD;
         end else if (gap_tick) begin
            gap_cnt <= gap_cnt - 1'b1;
         end

         if (abort) aborted <= 1'b1;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_usb_tx_pkt_scheduler.sv
// Self-checking bench for usb_tx_pkt_scheduler: directed scenarios plus random traffic,
// compared every cycle against a transaction/timestamp model of the scheduler.
module tb_usb_tx_pkt_scheduler;

   localparam logic [255:0] HASH_VEC =
      256'h00000000000080b66c911bd5ba14a74260057311eaeb1982802f7010f1a9f090;

   logic         clk = 1'b0;
   logic         rst, hash_req, hs_req, read_enable, tx_error;
   logic [255:0] hash_in;
   logic [7:0]   hs_pid;
   logic [15:0]  tx_data;
   logic         transmit_start, transmit_empty, hash_ack, hs_ack;
   logic         hash_done, hs_done, pkt_err, busy;

   usb_tx_pkt_scheduler dut (
      .clk(clk), .rst(rst), .hash_req(hash_req), .hash_in(hash_in),
      .hs_req(hs_req), .hs_pid(hs_pid), .read_enable(read_enable), .tx_error(tx_error),
      .tx_data(tx_data), .transmit_start(transmit_start), .transmit_empty(transmit_empty),
      .hash_ack(hash_ack), .hs_ack(hs_ack), .hash_done(hash_done), .hs_done(hs_done),
      .pkt_err(pkt_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: a packet is a list of words plus timestamps (grant edge, end edge).
   int          n_edge  = 0;
   bit          m_busy  = 1'b0;
   bit          m_hash  = 1'b0;
   bit          m_abort = 1'b0;
   int          m_grant = 0;
   int          m_end   = -1;
   int          m_reads = 0;
   int          m_nwords = 0;
   logic [15:0] m_words [17];

   logic [15:0] e_tx_data = '0;
   bit e_empty = 1'b1, e_start = 1'b0, e_hs_ack = 1'b0, e_hash_ack = 1'b0;
   bit e_hs_done = 1'b0, e_hash_done = 1'b0, e_err = 1'b0, e_busy = 1'b0;

   always @(posedge clk) begin
      n_edge++;
      e_start = 0; e_hs_ack = 0; e_hash_ack = 0; e_hs_done = 0; e_hash_done = 0; e_err = 0;
      if (rst) begin
         m_busy    = 0;
         e_tx_data = '0;
         e_empty   = 1;
      end else if (!m_busy) begin
         if (hs_req || hash_req) begin
            m_busy   = 1;
            m_hash   = !hs_req;
            m_abort  = 0;
            m_grant  = n_edge;
            m_end    = -1;
            m_reads  = 0;
            m_nwords = m_hash ? 17 : 1;
            m_words[0] = {8'h80, (m_hash ? 8'hC3 : hs_pid)};
            for (int i = 1; i < 17; i++) m_words[i] = 16'(hash_in >> (256 - 16 * i));
            e_tx_data = m_words[0];
            e_empty   = 0;
            if (m_hash) e_hash_ack = 1; else e_hs_ack = 1;
         end
      end else if (tx_error) begin
         e_err   = 1;
         e_empty = 1;
         m_abort = 1;
         m_end   = n_edge + 64;
      end else if (n_edge == m_end) begin
         m_busy = 0;
         if (!m_abort) begin
            if (m_hash) e_hash_done = 1; else e_hs_done = 1;
         end
      end else if (n_edge == m_grant + 1) begin
         e_start = 1;
      end else if (m_end < 0 && read_enable) begin
         m_reads++;
         if (m_reads < m_nwords) e_tx_data = m_words[m_reads];
         else begin
            e_empty = 1;
            m_end   = n_edge + 64;
         end
      end
      e_busy = m_busy;
   end

   int rd_pct   = 0;
   int err_pm   = 0;
   bit auto_req = 0;

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   // One clock: compare all outputs at the falling edge, then drive the next inputs.
   task automatic step();
      @(negedge clk);
      check("tx_data", tx_data, e_tx_data);
      check("transmit_empty", transmit_empty, e_empty);
      check("transmit_start", transmit_start, e_start);
      check("hs_ack", hs_ack, e_hs_ack);
      check("hash_ack", hash_ack, e_hash_ack);
      check("hs_done", hs_done, e_hs_done);
      check("hash_done", hash_done, e_hash_done);
      check("pkt_err", pkt_err, e_err);
      check("busy", busy, e_busy);
      if (e_hs_ack)   hs_req   = 0;
      if (e_hash_ack) hash_req = 0;
      read_enable = ($urandom_range(99) < rd_pct);
      tx_error    = ($urandom_range(999) < err_pm);
      if (auto_req) begin
         if (!hs_req && $urandom_range(99) < 3) begin
            hs_req = 1;
            hs_pid = 8'($urandom);
         end
         if (!hash_req && $urandom_range(99) < 5) begin
            hash_req = 1;
            hash_in  = rand256();
         end
      end
   endtask

   task automatic run_idle(input string tag, input int budget);
      int k = 0;
      do begin
         step();
         k++;
      end while ((e_busy || hs_req || hash_req) && k < budget);
      check({tag, "_timeout"}, k < budget, 1);
      read_enable = 0;
      tx_error    = 0;
   endtask

   task automatic read_pulse();
      read_enable = 1;
      step();
      step();
   endtask

   initial begin
      int k, seen;
      logic [255:0] rx;
      rst = 1; hash_req = 0; hash_in = '0; hs_req = 0; hs_pid = '0;
      read_enable = 0; tx_error = 0;

      // Reset held two cycles with a pending hash request
      hash_req = 1;
      hash_in  = rand256();
      step();
      step();
      check("rst_no_ack", hash_ack, 0);
      check("rst_busy", busy, 0);
      check("rst_tx_data", tx_data, 16'h0000);
      check("rst_empty", transmit_empty, 1);
      rst = 0;
      step();
      check("ack_after_rst", hash_ack, 1);
      rd_pct = 40;
      run_idle("rst_pkt", 500);
      rd_pct = 0;

      // Handshake packet
      hs_req = 1;
      hs_pid = 8'hD2;
      step();
      check("hs_ack_seen", hs_ack, 1);
      check("hs_header", tx_data, 16'h80D2);
      step();
      check("hs_start_seen", transmit_start, 1);
      check("hs_empty_before", transmit_empty, 0);
      read_enable = 1;
      step();
      check("hs_empty_after", transmit_empty, 1);
      k = 0;
      do begin step(); k++; end while (!hs_done && k < 100);
      check("hs_done_delay", k, 64);

      // Hash packet with the reference vector, captured as an RX loopback would
      hash_req = 1;
      hash_in  = HASH_VEC;
      step();
      check("hash_ack_seen", hash_ack, 1);
      step();
      check("hash_start_seen", transmit_start, 1);
      rx = '0;
      for (int r = 0; r < 17; r++) begin
         if (r == 0) check("hash_header", tx_data, 16'h80C3);
         else        rx = {rx[239:0], tx_data};
         read_pulse();
      end
      check("hash_loopback", rx, HASH_VEC);
      check("hash_empty_end", transmit_empty, 1);
      k = 0;
      do begin step(); k++; end while (!hash_done && k < 100);
      check("hash_done_seen", hash_done, 1);

      // Simultaneous requests: handshake wins, hash follows right after hs_done
      hs_req = 1; hs_pid = 8'h5A;
      hash_req = 1; hash_in = rand256();
      step();
      check("prio_hs_first", hs_ack, 1);
      check("prio_hash_waits", hash_ack, 0);
      rd_pct = 40;
      k = 0;
      do begin step(); k++; end while (!hs_done && k < 300);
      check("prio_hs_done", hs_done, 1);
      rd_pct = 0;
      step();
      check("prio_hash_next", hash_ack, 1);
      rd_pct = 40;
      run_idle("prio", 500);
      rd_pct = 0;

      // tx_error after the 5th read of a hash packet, then a retry
      hash_req = 1;
      hash_in  = rand256();
      step();
      step();
      for (int r = 0; r < 5; r++) read_pulse();
      tx_error = 1;
      step();
      check("err_pulse", pkt_err, 1);
      check("err_empty", transmit_empty, 1);
      k = 0;
      seen = 0;
      do begin
         step();
         k++;
         if (hash_done) seen++;
      end while (busy && k < 100);
      check("err_gap_len", k, 64);
      check("err_no_done", seen, 0);
      hash_req = 1;
      step();
      check("retry_ack", hash_ack, 1);
      check("retry_header", tx_data, 16'h80C3);
      rd_pct = 40;
      run_idle("retry", 500);
      rd_pct = 0;

      // Reset in the middle of a hash packet, then a normal handshake
      hash_req = 1;
      hash_in  = rand256();
      step();
      step();
      for (int r = 0; r < 8; r++) read_pulse();
      rst = 1;
      step();
      check("mid_rst_tx_data", tx_data, 16'h0000);
      check("mid_rst_empty", transmit_empty, 1);
      check("mid_rst_busy", busy, 0);
      rst = 0;
      hs_req = 1;
      hs_pid = 8'h1E;
      step();
      check("post_rst_hs_ack", hs_ack, 1);
      rd_pct = 40;
      k = 0;
      do begin step(); k++; end while (!hs_done && k < 300);
      check("post_rst_hs_done", hs_done, 1);
      run_idle("post_rst", 500);

      // Random traffic with occasional transmit errors
      auto_req = 1;
      rd_pct   = 35;
      err_pm   = 10;
      repeat (3000) step();
      auto_req = 0;
      err_pm   = 0;
      run_idle("random", 2000);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/usb_tx_pkt_scheduler.md
Name: usb_tx_pkt_scheduler

Overview:
Packet scheduler in front of the USB TX top level. It arbitrates between two requesters:
- the hash-result path, which sends a 256-bit hash as a DATA packet;
- the protocol engine, which sends a handshake packet (ACK/NAK/STALL).
It issues transmit_start, presents 16-bit words on tx_data and advances on each read_enable from the TX. It also enforces an inter-packet gap before granting the next packet.

Parameters:
SYNC_BYTE, 8'h80, upper byte of every header word.
DATA_PID, 8'hC3, PID byte placed in the hash packet header.
GAP_CYCLES, 64, clk cycles held idle after the last word is consumed (EOP plus bus gap; 8 clk per bit).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous active-high reset.
hash_req  in  1  level; hash packet pending; held until hash_ack.
hash_in  in  256  hash value, valid while hash_req=1.
hs_req  in  1  level; handshake packet pending; held until hs_ack.
hs_pid  in  8  handshake PID byte, valid while hs_req=1.
read_enable  in  1  TX consumed current tx_data (1-cycle pulse).
tx_error  in  1  TX reports transmit error.
tx_data  out  16  word presented to TX.
transmit_start  out  1  1-cycle pulse starting a packet.
transmit_empty  out  1  1 = no unconsumed word held.
hash_ack  out  1  1-cycle pulse; hash_in latched, requester may drop.
hs_ack  out  1  1-cycle pulse; hs_pid latched.
hash_done  out  1  1-cycle pulse; hash packet fully sent, gap elapsed.
hs_done  out  1  1-cycle pulse; handshake packet sent, gap elapsed.
pkt_err  out  1  1-cycle pulse; packet aborted by tx_error.
busy  out  1  1 in any state except IDLE.

Behaviour:
- Reset (rst=1 at a clk edge, including mid-packet): next state IDLE. tx_data=0, transmit_empty=1, busy=0, all pulse outputs 0. Shift register and counters cleared.
- FSM states: IDLE, START, SEND, GAP.
- IDLE: grant is decided by fixed priority, hs_req over hash_req.
  - Grant at edge G: latch payload and pulse the matching ack in cycle G+1. Load tx_data={SYNC_BYTE, pid} with pid=hs_pid or DATA_PID. Set word_cnt=0, transmit_empty=0, go to START.
  - No preemption: a request arriving mid-packet waits for IDLE.
- START: transmit_start=1 for exactly one cycle, then SEND. read_enable in START is ignored.
- SEND: on each read_enable pulse, next cycle:
  - hash packet, word_cnt<16: tx_data=hash[255-16*word_cnt -: 16] (first word 255:240, last word 15:0); word_cnt++.
  - last word consumed (handshake: header; hash: the 17th read_enable): transmit_empty=1, tx_data held, go to GAP with gap counter=GAP_CYCLES-1.
  - Between read_enable pulses, tx_data is stable.
- GAP:
  - Counter decrements each cycle; read_enable is ignored.
  - At 0: pulse hash_done or hs_done, go to IDLE.
  - A new grant is possible the cycle after done.
- tx_error in START, SEND or GAP:
  - Next cycle: pkt_err=1, transmit_empty=1, go to GAP. The full gap is enforced.
  - The done pulse is suppressed. Leaving GAP after an aborted packet gives no done pulse.
  - The requester has already been acked. Any retry is the requester's job (reassert req).
  - tx_error wins over a simultaneous read_enable.
- Latency: grant edge to transmit_start high is 2 cycles. read_enable to new tx_data is 1 cycle.
- Requests held continuously are served back-to-back, separated by GAP_CYCLES. hs_req can starve hash_req by design.

Test Plan:
- Reset: hold rst 2 cycles with hash_req=1 -> tx_data=0, transmit_empty=1, busy=0, no ack. After release, hash_ack within 1 cycle.
- Handshake: hs_req=1, hs_pid=8'hD2 -> hs_ack, tx_data=16'h80D2, one transmit_start pulse. After 1 read_enable, transmit_empty=1. hs_done exactly 64 cycles later.
- Hash packet: hash_in=256'h00000000000080b66c911bd5ba14a74260057311eaeb1982802f7010f1a9f090 -> header 16'h80C3, then words 0000,0000,0000,80b6,…,f090 over 16 read_enables (RX loopback bytes match). Then hash_done.
- Priority: hash_req and hs_req asserted in the same cycle -> handshake sent first. Hash granted the cycle after hs_done. No transmit_start overlap.
- Error: tx_error after 5th read_enable of a hash packet -> pkt_err pulse, transmit_empty=1, no hash_done. busy drops after 64 cycles. A reasserted hash_req is resent from the header.
- Mid-packet reset: rst during SEND word 8 -> outputs at reset values next cycle. A following hs_req is served normally.
